// File: rtl/seq_pkg.sv
// Shared types and defaults for the score sequencer: state encoding, field widths,
// and helpers that split a score entry into its {note, dur} fields.
package seq_pkg;

  localparam int SEQ_ADDR_W = 8;
  localparam int SEQ_NOTE_W = 4;
  localparam int SEQ_DUR_W  = 4;

  localparam logic [SEQ_NOTE_W-1:0] REST_CODE = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PLAY,
    ST_GAP,
    ST_PAUSED,
    ST_DONE
  } seq_state_t;

  function automatic logic [SEQ_NOTE_W-1:0] entry_note(input logic [SEQ_NOTE_W+SEQ_DUR_W-1:0] e);
    return e[SEQ_NOTE_W+SEQ_DUR_W-1 -: SEQ_NOTE_W];
  endfunction

  function automatic logic [SEQ_DUR_W-1:0] entry_dur(input logic [SEQ_NOTE_W+SEQ_DUR_W-1:0] e);
    return e[SEQ_DUR_W-1:0];
  endfunction

endpackage

// File: rtl/score_sequencer_beat_timer.sv
// Beat counter shared by the note and gap phases: clear > load > increment, else hold.
// hit flags the increment that lands the count on the terminal value.
module beat_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] terminal,
  output logic [W-1:0] count,
  output logic         hit
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  assign hit = inc && ((count + W'(1)) == terminal);

endmodule

// File: rtl/score_sequencer.sv
// Melody playback sequencer: walks {note, dur} score entries from a sync ROM, times notes
// and articulation gaps in beat ticks, with start/pause/stop. SEQ_LOOP_EN: loop score forever.
module score_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W    = SEQ_ADDR_W,
  parameter int NOTE_W    = SEQ_NOTE_W,
  parameter int DUR_W     = SEQ_DUR_W,
  parameter int GAP_TICKS = 1
) (
  input  logic                    clk100mhz,
  input  logic                    clr,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    stop,
  input  logic                    beat_tick,
  input  logic [ADDR_W-1:0]       score_len,
  output logic                    rom_rd,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note_out,
  output logic                    note_valid,
  output logic [ADDR_W-1:0]       play_pos,
  output logic                    busy,
  output logic                    done
);

  localparam logic [DUR_W-1:0] GAP_TERM = DUR_W'(GAP_TICKS);

  seq_state_t state, nxt, ret_state;

  logic [ADDR_W-1:0] pos, len_q;
  logic [NOTE_W-1:0] note_q;
  logic [DUR_W-1:0]  dur_q, saved_cnt, count, terminal;
  logic              pend, done_q, nv_q, hit, is_last;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  logic t_clr, t_load, t_inc;
  logic start_run, begin_play, take_pause, defer_pause, resume;
  logic to_gap, entry_end, advance, wrap, finish;

  assign rom_note = entry_note(rom_data);
  assign rom_dur  = entry_dur(rom_data);
  assign is_last  = (pos == (len_q - ADDR_W'(1)));
  assign terminal = (state == ST_GAP) ? GAP_TERM : dur_q;

  beat_timer #(.W(DUR_W)) u_timer (
    .clk      (clk100mhz),
    .rst      (clr),
    .clear    (t_clr),
    .load     (t_load),
    .load_val (saved_cnt),
    .inc      (t_inc),
    .terminal (terminal),
    .count    (count),
    .hit      (hit)
  );

  always_ff @(posedge clk100mhz or posedge clr) begin
    if (clr) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt         = state;
    t_clr       = 1'b0;
    t_load      = 1'b0;
    t_inc       = 1'b0;
    start_run   = 1'b0;
    begin_play  = 1'b0;
    take_pause  = 1'b0;
    defer_pause = 1'b0;
    resume      = 1'b0;
    to_gap      = 1'b0;
    entry_end   = 1'b0;
    advance     = 1'b0;
    wrap        = 1'b0;
    finish      = 1'b0;
    if (stop) begin
      nxt   = ST_IDLE;
      t_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (score_len == '0) begin
              nxt    = ST_DONE;
              finish = 1'b1;
            end else begin
              nxt       = ST_FETCH;
              start_run = 1'b1;
            end
          end
        end
        ST_FETCH: begin
          nxt         = ST_WAIT;
          defer_pause = pause;
        end
        ST_WAIT: begin
          nxt         = ST_PLAY;
          begin_play  = 1'b1;
          defer_pause = pause;
          t_clr       = 1'b1;
        end
        ST_PLAY: begin
          // A pause held over from FETCH/WAIT lands here, on the first PLAY cycle.
          if (pause || pend) begin
            nxt        = ST_PAUSED;
            take_pause = 1'b1;
          end else if (beat_tick) begin
            t_inc = 1'b1;
            if (hit) begin
              if (GAP_TICKS > 0) begin
                nxt    = ST_GAP;
                to_gap = 1'b1;
                t_clr  = 1'b1;
              end else begin
                entry_end = 1'b1;
              end
            end
          end
        end
        ST_GAP: begin
          if (pause) begin
            nxt        = ST_PAUSED;
            take_pause = 1'b1;
          end else if (beat_tick) begin
            t_inc     = 1'b1;
            entry_end = hit;
          end
        end
        ST_PAUSED: begin
          if (pause || start) begin
            nxt    = ret_state;
            resume = 1'b1;
            t_load = 1'b1;
          end
        end
        default: nxt = ST_IDLE;
      endcase
      if (entry_end) begin
        t_clr = 1'b1;
        if (is_last) begin
`ifdef SEQ_LOOP_EN
          nxt  = ST_FETCH;
          wrap = 1'b1;
`else
          nxt    = ST_DONE;
          finish = 1'b1;
`endif
        end else begin
          nxt     = ST_FETCH;
          advance = 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy     = (state != ST_IDLE) && (state != ST_DONE);
    rom_rd   = (state == ST_FETCH);
    rom_addr = rom_rd ? pos : '0;
  end

  always_ff @(posedge clk100mhz or posedge clr) begin
    if (clr) begin
      pos       <= '0;
      len_q     <= '0;
      note_q    <= '0;
      dur_q     <= '0;
      saved_cnt <= '0;
      ret_state <= ST_IDLE;
      pend      <= 1'b0;
      nv_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        pos    <= '0;
        note_q <= '0;
        nv_q   <= 1'b0;
        pend   <= 1'b0;
      end else begin
        if (start_run) begin
          len_q <= score_len;
          pos   <= '0;
          pend  <= 1'b0;
        end
        if (defer_pause) pend <= 1'b1;
        if (begin_play) begin
          note_q <= rom_note;
          dur_q  <= (rom_dur == '0) ? DUR_W'(1) : rom_dur;
          nv_q   <= (rom_note != REST_CODE);
        end
        if (take_pause) begin
          pend      <= 1'b0;
          ret_state <= state;
          saved_cnt <= count;
          nv_q      <= 1'b0;
        end
        if (resume) nv_q <= (ret_state == ST_PLAY) && (note_q != REST_CODE);
        if (to_gap) nv_q <= 1'b0;
        if (advance) begin
          pos  <= pos + ADDR_W'(1);
          nv_q <= 1'b0;
        end
        if (wrap) begin
          pos    <= '0;
          nv_q   <= 1'b0;
          done_q <= 1'b1;
        end
        if (finish) begin
          done_q <= 1'b1;
          note_q <= '0;
          nv_q   <= 1'b0;
        end
      end
    end
  end

  assign note_out   = note_q;
  assign note_valid = nv_q;
  assign play_pos   = pos;
  assign done       = done_q;

endmodule
